// File: rtl/pipelined_adder_subtractor_pkg.sv
// Shared ALU definitions: flag bit positions, op encoding and the one-bit
// full-adder cell that every chunk adder is built from.
package pipelined_adder_subtractor_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_W = 4;

  localparam logic SUB_OP = 1'b1;

  typedef logic [FLAG_W-1:0] flags_t;

  // Returns {carry_out, sum} for one bit position.
  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic ci);
    logic sum_b;
    logic carry_b;
    sum_b   = a ^ b ^ ci;
    carry_b = (a & b) | (ci & (a ^ b));
    return {carry_b, sum_b};
  endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// Combinational W-bit ripple adder for one pipeline chunk: s = a + bx + cin.
// The operand inversion for subtraction happens upstream, so this is a pure add.
module add_sub_chunk
  import pipelined_adder_subtractor_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] bx,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] carry;

  // ripple the carry across the chunk, one full-adder cell per bit
  always_comb begin
    carry    = {(W+1){1'b0}};
    s        = {W{1'b0}};
    carry[0] = cin;
    for (int i = 0; i < W; i++) begin
      {carry[i+1], s[i]} = full_adder(a[i], bx[i], carry[i]);
    end
  end

  assign cout = carry[W];

endmodule

// File: rtl/pipelined_adder_subtractor.sv
// Pipelined N-bit adder/subtractor: the carry chain is cut into STAGES chunks,
// one chunk resolved per clock, with valid/ready flow control and a global stall.
module pipelined_adder_subtractor
  import pipelined_adder_subtractor_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         V,
  output logic         Z,
  output logic         Nf
);

  localparam int ST_SAFE = (STAGES < 1) ? 1 : STAGES;
  localparam int W       = N / ST_SAFE;

  if ((STAGES < 1) || (STAGES > N)) begin : g_bad_stages
    $fatal(1, "pipelined_adder_subtractor: STAGES must lie in 1..N");
  end
  if ((N % ST_SAFE) != 0) begin : g_bad_split
    $fatal(1, "pipelined_adder_subtractor: N must be a multiple of STAGES");
  end

  logic   advance;
  logic   sub_en;
  flags_t out_flags;

  assign sub_en   = (sub == SUB_OP);
  // Any held result freezes every stage, bubbles included, so order is kept.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * W;
    localparam int REM = N - LO;

    logic              vin;
    logic              cin;
    logic [REM-1:0]    ain;
    logic [REM-1:0]    bxin;
    logic [W-1:0]      csum;
    logic              ccout;
    logic [LO+W-1:0]   s_d;
    logic              vld_q;
    logic [LO+W-1:0]   s_q;

    if (k == 0) begin : g_in
      assign vin  = in_valid;
      assign cin  = sub_en;
      assign ain  = A;
      assign bxin = B ^ {N{sub_en}};
      assign s_d  = csum;
    end else begin : g_in
      assign vin  = g_stage[k-1].vld_q;
      assign cin  = g_stage[k-1].g_fwd.cy_q;
      assign ain  = g_stage[k-1].g_fwd.a_q;
      assign bxin = g_stage[k-1].g_fwd.bx_q;
      assign s_d  = {csum, g_stage[k-1].s_q};
    end

    add_sub_chunk #(.W(W)) u_chunk (
      .a    (ain[W-1:0]),
      .bx   (bxin[W-1:0]),
      .cin  (cin),
      .s    (csum),
      .cout (ccout)
    );

    // valid always follows the pipe; payload only loads when live data arrives
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        s_q   <= {(LO+W){1'b0}};
      end else if (advance) begin
        vld_q <= vin;
        if (vin) begin
          s_q <= s_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic               cy_q;
      logic [REM-W-1:0]   a_q;
      logic [REM-W-1:0]   bx_q;

      // carry and skew buffer of operand chunks not yet consumed
      always_ff @(posedge clk) begin
        if (rst) begin
          cy_q <= 1'b0;
          a_q  <= {(REM-W){1'b0}};
          bx_q <= {(REM-W){1'b0}};
        end else if (advance && vin) begin
          cy_q <= ccout;
          a_q  <= ain[REM-1:W];
          bx_q <= bxin[REM-1:W];
        end
      end
    end else begin : g_last
      flags_t flags_d;
      flags_t flags_q;

      // the top chunk holds both operand sign bits, so overflow is local here
      always_comb begin
        flags_d         = {FLAG_W{1'b0}};
        flags_d[FLAG_C] = ccout;
        flags_d[FLAG_V] = (ain[W-1] == bxin[W-1]) && (csum[W-1] != ain[W-1]);
        flags_d[FLAG_Z] = (s_d == {N{1'b0}});
        flags_d[FLAG_N] = s_d[N-1];
      end

      // flags register alongside the final result chunk
      always_ff @(posedge clk) begin
        if (rst) begin
          flags_q <= {FLAG_W{1'b0}};
        end else if (advance && vin) begin
          flags_q <= flags_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign S         = g_stage[STAGES-1].s_q;
  assign out_flags = g_stage[STAGES-1].g_last.flags_q;
  assign Cout      = out_flags[FLAG_C];
  assign V         = out_flags[FLAG_V];
  assign Z         = out_flags[FLAG_Z];
  assign Nf        = out_flags[FLAG_N];

endmodule

// File: tb/tb_pipelined_adder_subtractor.sv
// Self-checking bench: arithmetic reference model + scoreboard on a 32-bit/4-stage
// instance, plus directed latency/result checks on 8-bit 1-stage and 8-stage builds.
module tb_pipelined_adder_subtractor;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sub;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;
  logic        Cout, V, Z, Nf;

  logic       v8, sub8;
  logic [7:0] a8, b8;
  logic       rdy1, ov1, c1, vv1, z1, n1;
  logic       rdy8, ov8, c8, vv8, z8, n8;
  logic [7:0] s1, s8;

  int checks = 0;
  int failures = 0;
  int results_seen = 0;
  res_t exp_q[$];

  pipelined_adder_subtractor #(.N(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .V(V), .Z(Z), .Nf(Nf)
  );

  pipelined_adder_subtractor #(.N(8), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy1), .sub(sub8),
    .A(a8), .B(b8), .out_valid(ov1), .out_ready(1'b1),
    .S(s1), .Cout(c1), .V(vv1), .Z(z1), .Nf(n1)
  );

  pipelined_adder_subtractor #(.N(8), .STAGES(8)) dut_s8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .sub(sub8),
    .A(a8), .B(b8), .out_valid(ov8), .out_ready(1'b1),
    .S(s8), .Cout(c8), .V(vv8), .Z(z8), .Nf(n8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference arithmetic in wide integers: unsigned for carry, signed for overflow.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sb);
    longint ua, ub, sa, sbv, r_u, r_s;
    res_t r;
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sa  = $signed(a);
    sbv = $signed(b);
    if (sb) begin
      r_u = ua - ub;
      r_s = sa - sbv;
      r.c = (ua >= ub);
    end else begin
      r_u = ua + ub;
      r_s = sa + sbv;
      r.c = (r_u > 64'sd4294967295);
    end
    r.s = r_u[31:0];
    r.v = (r_s > 64'sd2147483647) || (r_s < -64'sd2147483648);
    r.z = (r.s == 32'd0);
    r.n = r.s[31];
    return r;
  endfunction

  // Scoreboard: predicts on accept, compares on transfer, checks stall hold.
  logic        prev_stall = 1'b0;
  logic [36:0] prev_snap;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (prev_stall) begin
        chk("stall_hold", {27'd0, out_valid, S, Cout, V, Z, Nf}, {27'd0, prev_snap});
      end
      if (out_valid && out_ready) begin
        results_seen++;
        if (exp_q.size() == 0) begin
          chk("spurious_result", 64'd1, 64'd0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("scoreboard", {28'd0, S, Cout, V, Z, Nf}, {28'd0, e});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(A, B, sub));
      end
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_snap  = {out_valid, S, Cout, V, Z, Nf};
  end

  task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic sb, input logic [35:0] req);
    int   n;
    logic seen;
    res_t m;
    m = model(a, b, sb);
    chk({nm, "_model"}, {28'd0, m}, {28'd0, req});
    A = a; B = b; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = 32'hDEADBEEF; B = 32'h0BADF00D; sub = ~sb;
    n = 1;
    seen = 1'b0;
    while (!seen && n <= 20) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        chk({nm, "_latency"}, 64'(n), 64'd4);
        chk({nm, "_result"}, {28'd0, S, Cout, V, Z, Nf}, {28'd0, req});
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!seen) chk({nm, "_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b,
                      input logic sb, input logic [11:0] req);
    int n, lat1, lat8;
    a8 = a; b8 = b; sub8 = sb; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
    n = 1; lat1 = 0; lat8 = 0;
    while ((lat1 == 0 || lat8 == 0) && n <= 20) begin
      @(negedge clk);
      if (ov1 && lat1 == 0) begin
        lat1 = n;
        chk({nm, "_s1_result"}, {52'd0, s1, c1, vv1, z1, n1}, {52'd0, req});
      end
      if (ov8 && lat8 == 0) begin
        lat8 = n;
        chk({nm, "_s8_result"}, {52'd0, s8, c8, vv8, z8, n8}, {52'd0, req});
      end
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_s1_latency"}, 64'(lat1), 64'd1);
    chk({nm, "_s8_latency"}, 64'(lat8), 64'd8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, low_cnt;
    rst = 1'b1; in_valid = 1'b0; sub = 1'b0; A = 32'd0; B = 32'd0; out_ready = 1'b1;
    v8 = 1'b0; sub8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {27'd0, out_valid, S, Cout, V, Z, Nf}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    run_one("add_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, {32'h00000000, 4'b1010});
    run_one("sub_neg",   32'd5,        32'd7,        1'b1, {32'hFFFFFFFE, 4'b0001});
    run_one("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, {32'h80000000, 4'b0101});
    run_one("sub_ovf",   32'h80000000, 32'h00000001, 1'b1, {32'h7FFFFFFF, 4'b1100});
    run_one("sub_equal", 32'h12345678, 32'h12345678, 1'b1, {32'h00000000, 4'b1010});

    // back-to-back stream with a three-cycle consumer stall once results flow
    base = results_seen;
    low_cnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic acc;
          A = $urandom; B = $urandom; sub = i[0]; in_valid = 1'b1;
          do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
          end while (!acc);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        repeat (14) begin
          @(negedge clk);
          if (!in_ready) low_cnt++;
        end
      end
    join
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk("stall_in_ready_low_cycles", 64'(low_cnt), 64'd3);
    chk("stream_result_count", 64'(results_seen - base), 64'd8);

    // reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      A = 32'h1000 + 32'(i); B = 32'h0100; sub = i[0]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_flush_outputs", {27'd0, out_valid, S, Cout, V, Z, Nf}, 64'd0);
    chk("rst_flush_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    base = results_seen;
    run_one("after_rst", 32'd10, 32'd20, 1'b0, {32'd30, 4'b0000});
    repeat (6) @(posedge clk);
    #1;
    chk("after_rst_result_count", 64'(results_seen - base), 64'd1);

    run8("n8_sub_ovf", 8'h80, 8'h01, 1'b1, {8'h7F, 4'b1100});
    run8("n8_add_ovf", 8'h7F, 8'h01, 1'b0, {8'h80, 4'b0101});
    run8("n8_add_wrap", 8'hFF, 8'h01, 1'b0, {8'h00, 4'b1010});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_subtractor.md
# pipelined_adder_subtractor

Parametrised, pipelined successor to the team's ripple-carry adder/subtractor. The N-bit carry chain is split into STAGES equal chunks, with one chunk resolved per clock and the carry registered between chunks. This gives full throughput, with one operation per cycle. Each transaction carries its own add/sub mode and returns carry, overflow, zero and negative flags. The block sits in the ALU datapath behind operand issue and in front of result writeback, and uses a valid/ready handshake on both sides.

## Interface
- N, default 32: operand and result width.
- STAGES, default 4: pipeline depth. Must satisfy 1 ≤ STAGES ≤ N and N % STAGES == 0. Chunk width is W = N/STAGES.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and mode presented.
- in_ready  out  1  block can accept this cycle.
- sub  in  1  0 = A+B, 1 = A−B.
- A  in  N  operand A.
- B  in  N  operand B.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts this cycle.
- S  out  N  sum/difference.
- Cout  out  1  carry out of bit N−1. For subtraction, 1 means no borrow.
- V  out  1  signed overflow.
- Z  out  1  S == 0.
- Nf  out  1  S[N−1].

## Operation
- Arithmetic is S = A + (B ^ {N{sub}}) + sub, computed modulo 2^N. Cout is the true carry out of bit N−1.
- V = (A[N−1] == Bx[N−1]) && (S[N−1] != A[N−1]), where Bx = B ^ {N{sub}}.
- Stage k (k = 0..STAGES−1) adds chunk k of A and Bx plus the carry from stage k−1. Stage 0's carry-in is sub.
- Per-stage register contents:
  - valid bit;
  - sub;
  - the completed low result chunks;
  - the registered carry;
  - the not-yet-consumed upper chunks of A and Bx (skew buffer).
- Only chunk-sized adders exist; there is no N-bit carry path.
- The final stage register drives S, Cout, V, Z and Nf directly. Flags are computed on entry to the final register, so all outputs are registered.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational). This is a global stall: when out_valid && !out_ready, every stage register holds.
- While stalled, out_* data and out_valid are stable until the transfer occurs.
- Bubbles advance: a stage with valid = 0 is overwritten even when a later stage is occupied, provided the pipeline is not stalled.
- Ordering: results leave in acceptance order. There is no reordering, loss or duplication.
- Reset:
  - All valid bits clear, out_valid = 0.
  - S = 0, Cout = 0, V = 0, Z = 0, Nf = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-operation discards every in-flight transaction. No result from before reset ever appears on the outputs.
- Data presented while in_valid = 0 is ignored. Operand values only matter on accept.

## Timing
- Latency: an operation accepted at edge e appears with out_valid = 1 immediately after edge e+STAGES−1. That is STAGES cycles from the presenting cycle, assuming no stall.
- Throughput: one accept per cycle while out_ready = 1.
- When out_ready is high, accept and output transfer in the same cycle are legal and occur together.
- STAGES = 1: degenerates to a single registered full-width add with latency 1.
- A stall of k cycles delays every in-flight result by exactly k cycles.

## Structure
- Shared ALU package/header:
  - the flag-index constants (FLAG_C, FLAG_V, FLAG_Z, FLAG_N);
  - the op encoding SUB_OP = 1'b1.
- One sub-module, add_sub_chunk:
  - combinational W-bit adder of (a, bx, cin) producing (s, cout);
  - built from the team's existing full-adder cell;
  - instantiated STAGES times by a generate loop.
- Parameter legality (divisibility, range) is checked at elaboration and must stop compilation on violation.

## Test plan
- N=32, STAGES=4, add 0xFFFFFFFF + 0x00000001 → after 4 cycles: S=0x00000000, Cout=1, Z=1, V=0, Nf=0.
- Subtract 5 − 7 → S=0xFFFFFFFE, Cout=0, Nf=1, V=0, Z=0.
- Overflow cases:
  - add 0x7FFFFFFF + 1 → S=0x80000000, V=1, Cout=0;
  - sub 0x80000000 − 1 → S=0x7FFFFFFF, V=1, Cout=1.
- 8 back-to-back random ops with alternating sub, out_ready low for 3 cycles mid-stream → in_ready low exactly during the stall, outputs held stable, all 8 results in order and matching the reference model.
- Assert rst for one cycle with 3 ops in flight → out_valid = 0 the next cycle and all outputs 0. The next accepted op (10 + 20) returns S=30 after 4 cycles, and no stale result appears.
- Rebuild with N=8, STAGES=1: sub 0x80 − 0x01 → S=0x7F, V=1, Cout=1, latency 1. Rebuild with N=8, STAGES=8 and repeat → same result, latency 8.
